// File: rtl/decode_select_leds.sv
// Front-panel LED decoder: turns the frequency, lowpass and highpass select codes into
// one-hot indicators, blinks a group whose selection changed, and applies PWM dimming.

module decode_select_group #(
    parameter int unsigned FLASH_HALF  = 2500000,
    parameter int unsigned FLASH_COUNT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic change_i,
    output logic show_o,
    output logic flash_o
);
    localparam int unsigned HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int unsigned BW = (FLASH_COUNT > 0) ? $clog2(FLASH_COUNT + 1) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(FLASH_HALF - 1);
    localparam logic [BW-1:0] BLINKS    = BW'(FLASH_COUNT);

    typedef enum logic [1:0] {SOLID, FLASH_OFF, FLASH_ON} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] half_q, half_d;
    logic [BW-1:0] blink_q, blink_d;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SOLID;
            half_q  <= '0;
            blink_q <= '0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            blink_q <= blink_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        blink_d = blink_q;
        case (state_q)
            FLASH_OFF: begin
                if (half_q == HALF_LAST) begin
                    state_d = FLASH_ON;
                    half_d  = '0;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            FLASH_ON: begin
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    blink_d = blink_q + 1'b1;
                    state_d = (blink_d == BLINKS) ? SOLID : FLASH_OFF;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            default: ;
        endcase
        // A new selection always restarts the blink sequence from the dark half.
        if (change_i && (FLASH_COUNT > 0)) begin
            state_d = FLASH_OFF;
            half_d  = '0;
            blink_d = '0;
        end
        show_o  = (state_d != FLASH_OFF);
        flash_o = (state_d != SOLID);
    end
endmodule

module decode_select_leds #(
    parameter int unsigned FLASH_HALF  = 2500000,
    parameter int unsigned FLASH_COUNT = 3,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          freqSelect,
    input  logic [2:0]          lowpassSelect,
    input  logic [2:0]          highpassSelect,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [15:0]         leds,
    output logic [2:0]          flashing,
    output logic                selErr
);
    logic [2:0]          freq_q, lp_q, hp_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [15:0]         leds_q, leds_d;
    logic [2:0]          flashing_q, flash_d;
    logic                sel_err_q, sel_err_d;
    logic [2:0]          change, show;
    logic [15:0]         lit;
    logic                pwm_on;

    assign change = {highpassSelect != hp_q, lowpassSelect != lp_q, freqSelect != freq_q};

    decode_select_group #(.FLASH_HALF(FLASH_HALF), .FLASH_COUNT(FLASH_COUNT)) u_freq (
        .clk(clk), .reset(reset), .change_i(change[0]), .show_o(show[0]), .flash_o(flash_d[0])
    );
    decode_select_group #(.FLASH_HALF(FLASH_HALF), .FLASH_COUNT(FLASH_COUNT)) u_lowpass (
        .clk(clk), .reset(reset), .change_i(change[1]), .show_o(show[1]), .flash_o(flash_d[1])
    );
    decode_select_group #(.FLASH_HALF(FLASH_HALF), .FLASH_COUNT(FLASH_COUNT)) u_highpass (
        .clk(clk), .reset(reset), .change_i(change[2]), .show_o(show[2]), .flash_o(flash_d[2])
    );

    assign pwm_on = (brightness == '1) || (pwm_cnt_q < brightness);

    // Outputs are built from the incoming selects, since the select registers load them this edge.
    always_comb begin
        lit = '0;
        if (show[0]) lit[{1'b0, freqSelect}] = 1'b1;
        if (show[1] && !lowpassSelect[2]) lit[{2'b10, lowpassSelect[1:0]}] = 1'b1;
        if (show[2] && !highpassSelect[2]) lit[{2'b11, highpassSelect[1:0]}] = 1'b1;
        leds_d    = pwm_on ? lit : 16'h0000;
        sel_err_d = lowpassSelect[2] | highpassSelect[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freq_q     <= '0;
            lp_q       <= '0;
            hp_q       <= '0;
            pwm_cnt_q  <= '0;
            leds_q     <= '0;
            flashing_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            freq_q     <= freqSelect;
            lp_q       <= lowpassSelect;
            hp_q       <= highpassSelect;
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            leds_q     <= leds_d;
            flashing_q <= flash_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign leds     = leds_q;
    assign flashing = flashing_q;
    assign selErr   = sel_err_q;
endmodule

// File: tb/tb_decode_select_leds.sv
// Self-checking bench for decode_select_leds: vector table with a scoreboard queue,
// plus hand-written PWM duty sequences.

module tb_decode_select_leds;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  freqSelect = '0, lowpassSelect = '0, highpassSelect = '0;
    logic [3:0]  brightness = 4'hF;
    logic [15:0] leds;
    logic [2:0]  flashing;
    logic        selErr;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  f, l, h;
        logic [15:0] leds;
        logic [2:0]  fl;
        logic        err;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    decode_select_leds #(.FLASH_HALF(4), .FLASH_COUNT(2), .PWM_BITS(4)) dut (
        .clk(clk), .reset(reset), .freqSelect(freqSelect), .lowpassSelect(lowpassSelect),
        .highpassSelect(highpassSelect), .brightness(brightness), .leds(leds),
        .flashing(flashing), .selErr(selErr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic [2:0] f, l, h, input logic [15:0] el,
                       input logic [2:0] ef, input logic ee, input string name);
        vec_t v;
        v.rst = rst; v.f = f; v.l = l; v.h = h;
        v.leds = el; v.fl = ef; v.err = ee; v.name = name;
        vecs.push_back(v);
    endtask

    // Expected flash: dark 4, lit 4, dark 4, lit 4, then solid with the group flag cleared.
    task automatic add_flash(input logic [2:0] f, l, h, input logic [15:0] base, input int bit_i,
                             input logic [2:0] flag, input logic err, input int ncyc,
                             input string name);
        logic [15:0] one;
        one = 16'h0001 << bit_i;
        for (int k = 0; k < ncyc; k++) begin
            if (k < 16)
                add(1'b0, f, l, h, ((k % 8) >= 4) ? (base | one) : base, flag, err,
                    $sformatf("%s[%0d]", name, k));
            else
                add(1'b0, f, l, h, base | one, 3'b000, err, $sformatf("%s[%0d]", name, k));
        end
    endtask

    initial begin
        int cnt5, cnt8, cnt12;
        logic [15:0] stray, any_on;
        int bad;
        vec_t v, e;

        // Reset and idle
        for (int i = 0; i < 3; i++) add(1'b1, 3'd0, 3'd0, 3'd0, 16'h0000, 3'b000, 1'b0, "reset");
        for (int i = 0; i < 4; i++) add(1'b0, 3'd0, 3'd0, 3'd0, 16'h1101, 3'b000, 1'b0, "idle");
        // Frequency change
        add_flash(3'd5, 3'd0, 3'd0, 16'h1100, 5, 3'b001, 1'b0, 20, "freq0to5");
        // Restart mid-flash
        add_flash(3'd0, 3'd0, 3'd0, 16'h1100, 0, 3'b001, 1'b0, 20, "freq5to0");
        add_flash(3'd5, 3'd0, 3'd0, 16'h1100, 5, 3'b001, 1'b0, 6, "freq_pre");
        add_flash(3'd2, 3'd0, 3'd0, 16'h1100, 2, 3'b001, 1'b0, 20, "freq_restart");
        // Back to a clean idle before the multi-group case
        for (int i = 0; i < 2; i++) add(1'b1, 3'd0, 3'd0, 3'd0, 16'h0000, 3'b000, 1'b0, "reset2");
        add(1'b0, 3'd0, 3'd0, 3'd0, 16'h1101, 3'b000, 1'b0, "idle2");
        // Invalid lowpass with simultaneous highpass change
        add_flash(3'd0, 3'd6, 3'd3, 16'h0001, 15, 3'b110, 1'b1, 20, "lp_bad_hp3");
        add_flash(3'd0, 3'd1, 3'd3, 16'h8001, 9, 3'b010, 1'b0, 20, "lp1");
        // Reset during the lit half of a freq flash
        add_flash(3'd5, 3'd1, 3'd3, 16'h8200, 5, 3'b001, 1'b0, 6, "freq_pre_rst");
        for (int i = 0; i < 2; i++) add(1'b1, 3'd5, 3'd0, 3'd0, 16'h0000, 3'b000, 1'b0, "reset_mid");
        add_flash(3'd5, 3'd0, 3'd0, 16'h1100, 5, 3'b001, 1'b0, 20, "post_rst");

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            reset = v.rst;
            freqSelect = v.f;
            lowpassSelect = v.l;
            highpassSelect = v.h;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.name, ".leds"}, {16'h0, leds}, {16'h0, e.leds});
            check({e.name, ".flashing"}, {29'h0, flashing}, {29'h0, e.fl});
            check({e.name, ".selErr"}, {31'h0, selErr}, {31'h0, e.err});
        end

        // PWM at brightness 4: each lit LED on exactly 4 of 16 cycles
        @(negedge clk);
        brightness = 4'd4;
        @(posedge clk);
        cnt5 = 0; cnt8 = 0; cnt12 = 0; stray = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            cnt5 += int'(leds[5]);
            cnt8 += int'(leds[8]);
            cnt12 += int'(leds[12]);
            stray |= leds & ~16'h1120;
        end
        check("pwm4.bit5", cnt5, 4);
        check("pwm4.bit8", cnt8, 4);
        check("pwm4.bit12", cnt12, 4);
        check("pwm4.stray", {16'h0, stray}, 32'h0);

        // brightness 0: permanently dark
        @(negedge clk);
        brightness = 4'd0;
        @(posedge clk);
        any_on = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            any_on |= leds;
        end
        check("pwm0.dark", {16'h0, any_on}, 32'h0);

        // brightness 15: continuously on
        @(negedge clk);
        brightness = 4'hF;
        @(posedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (leds !== 16'h1120) bad++;
        end
        check("pwm15.solid_misses", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
